mux_rr_nto1: RTL and testbench
==============================

Name: mux_rr_nto1

Overview:
Parametrised N-to-1 channel multiplexer with a registered output and valid/ready handshakes on every channel. Successor to the combinational 2:1 mux family. Two selection modes:
- Round-robin arbitration across requesting channels.
- Fixed select from an external sel input.

Sits between multiple producer streams and a single consumer in lab datapaths.

Parameters:
- WIDTH, 8, data width per channel in bits.
- NCH, 4, number of input channels; legal range 2..16, need not be a power of two.
- SELW, 2, width of sel/out_sel; must satisfy 2**SELW >= NCH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SELW  channel index used when mode=1.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_sel  output  SELW  registered index of the channel held in out_data.
- xfer_cnt  output  16  output transfer count (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0, xfer_cnt=0.
  - in_ready is all-zero while rst_n=0.
- Load condition: load = !out_valid | out_ready. The output register accepts new data only when load=1.
- Grant, combinational, computed each cycle:
  - mode=0: search channels rr_ptr, rr_ptr+1, ... wrapping modulo NCH. First channel with in_valid=1 is granted.
  - mode=1: grant sel only if sel<NCH and in_valid[sel]=1. If sel>=NCH, no grant and all in_ready=0.
  - No requester: no grant.
- Ready/transfer:
  - in_ready[i] = load & granted & (grant==i). At most one in_ready bit is high.
  - Input transfer on channel i when in_valid[i] & in_ready[i].
  - On the clock edge of that transfer: out_data <= channel i data, out_sel <= i, out_valid <= 1.
- Drain: load=1 with no grant -> out_valid <= 0. out_data and out_sel hold their last values.
- Stall: out_valid=1 & out_ready=0 -> out_data, out_sel and out_valid hold; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer per cycle when out_ready is held high.
- Round-robin pointer:
  - After a transfer on channel g in mode=0, rr_ptr <= (g+1) mod NCH. Wrap from NCH-1 returns to 0 for any NCH.
  - mode=1 transfers leave rr_ptr unchanged.
- Mode or sel change: sampled combinationally each cycle. A value already held in the output register is never altered or dropped.
- Simultaneous load and output drain: when out_ready=1 and a grant exists in the same cycle, the new word replaces the old one without a bubble.
- Reset asserted mid-transfer: output is discarded immediately; no partial state survives.

Optional Feature:
Macro MUX_RR_XFER_CNT_EN.
- Defined: xfer_cnt increments by 1 on each output handshake (out_valid & out_ready). It saturates at 16'hFFFF and never wraps. Reset value is 0.
- Not defined: xfer_cnt is tied to 16'h0000 and no counter flops are inferred. The port is always present so benches are shared between both builds.

Test Plan:
1. Reset, mid-stream: apply rst_n=0 while out_valid=1 -> out_valid=0, out_sel=0, all in_ready=0 immediately (async). After release, first grant goes to channel 0.
2. Round-robin rotation: mode=0, in_valid=4'b1111, out_ready=1, channel i data=8'hA0+i -> out_data sequence A0,A1,A2,A3,A0, one per cycle; out_sel=0,1,2,3,0.
3. Sparse requesters: mode=0, in_valid=4'b1010 -> grants alternate 1,3,1,3. Then set in_valid=4'b0001 -> grant 0 next cycle with no idle cycle.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=8'h55 -> out_data holds 55 and in_ready=0000 for all 3 cycles. Raising out_ready delivers 55, and the next word loads on the same edge.
5. Fixed mode: mode=1, sel=2, in_valid=4'b1111 -> only channel 2 is accepted, every cycle. Then sel=3'd5 with NCH=5 (SELW=3) -> no grant, out_valid drops after drain.
6. Counter: with MUX_RR_XFER_CNT_EN, 10 handshakes -> xfer_cnt=10. Force a preload to 16'hFFFE, then 3 handshakes -> xfer_cnt=16'hFFFF. Without the macro, xfer_cnt=0 throughout.

Source files
------------

// File: rtl/mux_rr_nto1.sv
// N-to-1 valid/ready channel mux with a registered output, round-robin or fixed-select grant.
// Define MUX_RR_XFER_CNT_EN to build the saturating output-handshake counter on xfer_cnt.
module mux_rr_nto1 #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_sel,
  output logic [15:0]           xfer_cnt
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             load;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  assign load = !out_valid_q | out_ready;

  // Round-robin search starts at rr_ptr and wraps modulo NCH, so NCH need not be a power of two.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      for (int k = 0; k < NCH; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!gnt_vld && in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(gnt_idx) == i) gnt_data = in_data[i*WIDTH +: WIDTH];
      in_ready[i] = rst_n & load & gnt_vld & (int'(gnt_idx) == i);
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (gnt_vld) begin
        out_data_d  = gnt_data;
        out_sel_d   = gnt_idx;
        out_valid_d = 1'b1;
        if (!mode) begin
          rr_ptr_d = (int'(gnt_idx) == NCH - 1) ? '0 : SELW'(int'(gnt_idx) + 1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

`ifdef MUX_RR_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_valid_q && out_ready && xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt_q <= 16'h0000;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Self-checking bench for mux_rr_nto1: directed scenarios plus random traffic against a
// cycle-level reference model; a second 5-channel instance covers out-of-range fixed select.
module tb_mux_rr_nto1;
  localparam int N = 4;
`ifdef MUX_RR_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode, out_ready, out_valid;
  logic [1:0]  sel, out_sel;
  logic [7:0]  out_data;
  logic [15:0] xfer_cnt;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5, in_ready5;
  logic [2:0]  sel5, out_sel5;
  logic [7:0]  out_data5;
  logic        out_valid5;
  logic [15:0] xfer_cnt5;

  always #5 clk = ~clk;

  mux_rr_nto1 #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .xfer_cnt(xfer_cnt));

  mux_rr_nto1 #(.WIDTH(8), .NCH(5), .SELW(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .mode(1'b1), .sel(sel5), .out_data(out_data5), .out_valid(out_valid5), .out_ready(1'b1),
    .out_sel(out_sel5), .xfer_cnt(xfer_cnt5));

  int checks = 0;
  int fails  = 0;

  bit         m_valid;
  logic [7:0] m_data;
  int         m_sel, m_ptr, m_cnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_sel = 0; m_ptr = 0; m_cnt = 0;
  endtask

  function automatic int model_grant();
    if (mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs already applied; advances exactly one clock.
  task automatic cycle(string tag);
    int         g;
    bit         ld;
    logic [3:0] er;
    logic [7:0] gd;
    #1;
    ld = !m_valid || out_ready;
    g  = model_grant();
    er = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
    gd = (g >= 0) ? in_data[g*8 +: 8] : 8'h00;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    if (CNT_EN && m_valid && out_ready && m_cnt < 65535) m_cnt++;
    if (ld) begin
      if (g >= 0) begin
        m_data = gd; m_sel = g; m_valid = 1'b1;
        if (!mode) m_ptr = (g + 1) % N;
      end else m_valid = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
    chk({tag, ".out_sel"},   32'(out_sel),   32'(m_sel));
    chk({tag, ".xfer_cnt"},  32'(xfer_cnt),  32'(m_cnt));
  endtask

  initial begin
    rst_n = 1'b0; in_data = 32'hA3A2A1A0; in_valid = 4'hF; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    in_data5 = 40'hB4B3B2B1B0; in_valid5 = 5'h00; sel5 = 3'd0;
    model_reset();
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_sel", 32'(out_sel), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.xfer_cnt", 32'(xfer_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full rotation with every channel requesting
    for (int i = 0; i < 5; i++) begin
      cycle("rr");
      chk("rr.seq_data", 32'(out_data), 32'(8'hA0 + 8'(i % 4)));
      chk("rr.seq_sel", 32'(out_sel), 32'(i % 4));
    end

    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle("sparse");
      chk("sparse.sel", 32'(out_sel), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    in_valid = 4'b0001;
    cycle("sparse0");
    chk("sparse0.sel", 32'(out_sel), 32'd0);
    chk("sparse0.valid", 32'(out_valid), 32'd1);

    // Backpressure holds 55 while the next word waits on channel 0
    in_data = 32'hA3A2A155;
    cycle("bp_load");
    out_ready = 1'b0; in_data = 32'hA3A2A166;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall");
      chk("bp_stall.hold", 32'(out_data), 32'h55);
      chk("bp_stall.ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    chk("bp_release.next", 32'(out_data), 32'h66);

    // Asynchronous reset while the output holds a word
    in_valid = 4'hF; in_data = 32'hA3A2A1A0;
    #2; rst_n = 1'b0; #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.out_sel", 32'(out_sel), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    in_valid = 4'b1111;
    cycle("midrst_first");
    chk("midrst_first.sel", 32'(out_sel), 32'd0);

    // Fixed select on the 4-channel instance, in-range and out-of-range on the 5-channel one
    mode = 1'b1; sel = 2'd2;
    in_valid5 = 5'h1F; sel5 = 3'd4;
    for (int i = 0; i < 3; i++) begin
      cycle("fixed");
      chk("fixed.sel", 32'(out_sel), 32'd2);
    end
    chk("fix5.sel4", 32'(out_sel5), 32'd4);
    chk("fix5.data4", 32'(out_data5), 32'hB4);
    chk("fix5.valid", 32'(out_valid5), 32'd1);
    sel5 = 3'd5; #1;
    chk("fix5.ready_oor", 32'(in_ready5), 32'd0);
    cycle("fixed_more");
    chk("fix5.drain", 32'(out_valid5), 32'd0);
    chk("fix5.sel_hold", 32'(out_sel5), 32'd4);
    in_valid5 = 5'h00;

    // Ten handshakes from a clean counter
    mode = 1'b0; #2; rst_n = 1'b0; #1; model_reset();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
    for (int i = 0; i < 11; i++) cycle("cnt10");
    chk("cnt10.value", 32'(xfer_cnt), CNT_EN ? 32'd10 : 32'd0);
`ifdef MUX_RR_XFER_CNT_EN
    force dut.xfer_cnt_q = 16'hFFFE;
    #1; release dut.xfer_cnt_q;
    m_cnt = 65534;
    for (int i = 0; i < 3; i++) cycle("cnt_sat");
    chk("cnt_sat.value", 32'(xfer_cnt), 32'hFFFF);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      mode      = ($urandom_range(0, 3) == 0);
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
